// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and the decode stream.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RISC-V fetch stage: credit-limited in-order instruction fetch with a small response buffer
// and redirect handling that drops stale in-flight responses as they return.

module fetch_unit_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          rsp_valid,
  input logic [CW-1:0] inflight,
  input logic [CW-1:0] drop
);
  // A response must answer an outstanding request; dropped ones are a subset of in-flight ones.
  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> (inflight != '0));
  a_drop_le_inflight:   assert property (@(posedge clk) disable iff (rst) drop <= inflight);
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, buf_cnt_q, buf_cnt_d;
  logic [AW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [AW-1:0] buf_wp_q, buf_wp_d, buf_rp_q, buf_rp_d;
  logic [31:0]   tag_mem_q [DEPTH];
  logic [31:0]   tag_mem_d [DEPTH];
  logic [31:0]   buf_pc_q [DEPTH];
  logic [31:0]   buf_pc_d [DEPTH];
  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_instr_d [DEPTH];
  logic          credit_s, redir_s, req_valid_s, req_fire_s, rsp_s, keep_s, pop_s, out_valid_s;

  // Handshake qualifiers and next state; a redirect overrides every other event of its cycle.
  always_comb begin
    credit_s    = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < DEPTH_W;
    redir_s     = bus.redirect_valid;
    req_valid_s = credit_s && !redir_s && !rst;
    req_fire_s  = req_valid_s && bus.imem_req_ready;
    rsp_s       = bus.imem_rsp_valid;
    out_valid_s = buf_cnt_q != '0;
    keep_s      = rsp_s && (drop_q == '0) && !redir_s;
    pop_s       = out_valid_s && bus.out_ready && !redir_s;

    pc_d        = pc_q;
    tag_mem_d   = tag_mem_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    tag_wp_d    = tag_wp_q + AW'(req_fire_s);
    tag_rp_d    = tag_rp_q + AW'(rsp_s);
    inflight_d  = inflight_q + CW'(req_fire_s) - CW'(rsp_s);

    if (req_fire_s) begin
      tag_mem_d[tag_wp_q] = pc_q;
    end else begin
      tag_mem_d = tag_mem_q;
    end

    if (redir_s) begin
      // Every request still outstanding after this cycle belongs to the old path.
      pc_d      = bus.redirect_pc & 32'hFFFF_FFFC;
      drop_d    = inflight_q - CW'(rsp_s);
      buf_cnt_d = '0;
      buf_wp_d  = '0;
      buf_rp_d  = '0;
    end else begin
      pc_d      = req_fire_s ? (pc_q + 32'd4) : pc_q;
      drop_d    = (rsp_s && (drop_q != '0)) ? (drop_q - CW'(1)) : drop_q;
      buf_cnt_d = buf_cnt_q + CW'(keep_s) - CW'(pop_s);
      buf_wp_d  = buf_wp_q + AW'(keep_s);
      buf_rp_d  = buf_rp_q + AW'(pop_s);
    end

    if (keep_s) begin
      buf_pc_d[buf_wp_q]    = tag_mem_q[tag_rp_q];
      buf_instr_d[buf_wp_q] = bus.imem_rsp_data;
    end else begin
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC & 32'hFFFF_FFFC;
      inflight_q  <= '0;
      drop_q      <= '0;
      buf_cnt_q   <= '0;
      tag_wp_q    <= '0;
      tag_rp_q    <= '0;
      buf_wp_q    <= '0;
      buf_rp_q    <= '0;
      tag_mem_q   <= '{default: 32'h0};
      buf_pc_q    <= '{default: 32'h0};
      buf_instr_q <= '{default: 32'h0};
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      buf_cnt_q   <= buf_cnt_d;
      tag_wp_q    <= tag_wp_d;
      tag_rp_q    <= tag_rp_d;
      buf_wp_q    <= buf_wp_d;
      buf_rp_q    <= buf_rp_d;
      tag_mem_q   <= tag_mem_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_q & 32'hFFFF_FFFC;
  assign bus.out_valid      = out_valid_s;
  assign bus.out_pc         = buf_pc_q[buf_rp_q];
  assign bus.out_instr      = buf_instr_q[buf_rp_q];

  fetch_unit_chk #(.CW(int'(CW))) u_chk (
    .clk       (clk),
    .rst       (rst),
    .rsp_valid (rsp_s),
    .inflight  (inflight_q),
    .drop      (drop_q)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based model of the fetch stream.
module tb_fetch_unit;
  localparam int DEPTH = 2;

  typedef struct { logic [31:0] addr; bit live; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ob_t;
  typedef struct { logic [31:0] addr; int due; } mr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  fl_t         mq[$];
  ob_t         oq[$];
  mr_t         memq[$];
  logic [31:0] acc_log[$];
  logic [31:0] out_log[$];
  logic [31:0] mpc, hold_addr;
  int          cyc, total, bad, first_ov, lat_max;
  bit          hold_en, rsp_rand;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    mq.delete(); oq.delete(); memq.delete(); acc_log.delete(); out_log.delete();
    mpc = 32'h100;
    first_ov = -1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance model and memory.
  task automatic cycle(input bit rdy, input bit ordy, input bit redir, input logic [31:0] rpc);
    bit  rsp_v, exp_req, exp_ov, acc;
    fl_t f;
    ob_t o;
    mr_t m;
    rsp_v = 1'b0;
    if (memq.size() != 0) begin
      if (memq[0].due <= cyc && !(hold_en && memq[0].addr == hold_addr) &&
          (!rsp_rand || $urandom_range(0, 3) != 0)) rsp_v = 1'b1;
    end
    bus.imem_req_ready = rdy;
    bus.out_ready      = ordy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_v ? instr_of(memq[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_req = (mq.size() + oq.size() < DEPTH) && !redir;
    exp_ov  = oq.size() != 0;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", bus.imem_req_addr, mpc);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", bus.out_pc, oq[0].pc);
      chk("out_instr", bus.out_instr, oq[0].instr);
    end
    if (bus.out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
    if (bus.out_valid === 1'b1 && ordy && !redir) out_log.push_back(bus.out_pc);

    acc = (bus.imem_req_valid === 1'b1) && rdy;
    m.addr = bus.imem_req_addr;
    m.due  = cyc + int'($urandom_range(1, lat_max));
    if (rsp_v) void'(memq.pop_front());
    if (acc) begin
      memq.push_back(m);
      acc_log.push_back(m.addr);
    end

    if (!redir && exp_ov && ordy) void'(oq.pop_front());
    if (rsp_v && mq.size() != 0) begin
      f = mq.pop_front();
      if (f.live && !redir) begin
        o.pc = f.addr;
        o.instr = instr_of(f.addr);
        oq.push_back(o);
      end
    end
    if (redir) begin
      oq.delete();
      foreach (mq[i]) begin
        f = mq[i];
        f.live = 1'b0;
        mq[i] = f;
      end
      mpc = rpc & 32'hFFFF_FFFC;
    end else if (exp_req && rdy) begin
      f.addr = mpc;
      f.live = 1'b1;
      mq.push_back(f);
      mpc = mpc + 32'd4;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    total = 0; bad = 0; hold_en = 1'b0; hold_addr = 32'h0; rsp_rand = 1'b0; lat_max = 1;
    cyc = 0; first_ov = -1; mpc = 32'h100;

    // Reset, then decode backpressure straight away.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("first_out_valid_cycle", 32'(first_ov), 32'd2);
    chk("bp_req_count", 32'(acc_log.size()), 32'd2);
    chk("bp_held_pc", bus.out_pc, 32'h100);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("bp_resume_count_nonzero", 32'(out_log.size() >= 6), 32'd1);
    foreach (out_log[i]) chk("bp_resume_order", out_log[i], 32'h100 + 32'(i) * 32'd4);

    // Redirect with 0x108/0x10C held in flight.
    do_reset();
    hold_en = 1'b1; hold_addr = 32'h108;
    for (int i = 0; i < 20 && !(mq.size() == 2 && oq.size() == 0 && mpc == 32'h110); i++)
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_setup_last_acc", (acc_log.size() != 0) ? acc_log[$] : 32'h0, 32'h10C);
    acc_log.delete(); out_log.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'h203);
    hold_en = 1'b0;
    chk("redir_out_valid_flushed", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_acc_nonempty", 32'(acc_log.size() != 0 && out_log.size() != 0), 32'd1);
    if (acc_log.size() != 0) chk("redir_first_addr", acc_log[0], 32'h200);
    if (out_log.size() != 0) chk("redir_first_out_pc", out_log[0], 32'h200);

    // Memory stall holds the request.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_addr", bus.imem_req_addr, 32'h104);
    chk("stall_acc_count", 32'(acc_log.size()), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    if (acc_log.size() >= 2) chk("stall_resume_addr", acc_log[1], 32'h104);
    else chk("stall_resume_count", 32'(acc_log.size()), 32'd2);

    // Back-to-back redirects, last one at the top of the address space.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0500);
    acc_log.delete();
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_count", 32'(acc_log.size() >= 2), 32'd1);
    if (acc_log.size() >= 2) begin
      chk("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", acc_log[1], 32'h0000_0000);
    end

    // Async reset between edges with the buffer full.
    for (int i = 0; i < 10 && oq.size() < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    if (acc_log.size() != 0) chk("restart_addr", acc_log[0], 32'h100);
    else chk("restart_count", 32'(acc_log.size()), 32'd1);

    // Randomized traffic: stalls, backpressure, variable latency, redirects.
    lat_max = 3; rsp_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] r;
      r = $urandom();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            (i % 7 == 0) ? (32'hFFFF_FFF0 | {28'h0, r[3:0]}) : r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
